// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and shared memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_be;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic        timeout;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, m_ack, m_rdata,
      output if_done, if_rdata, ls_done, ls_rdata, m_req, m_we, m_addr, m_wdata, m_be, timeout
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, m_ack, m_rdata,
      input  if_done, if_rdata, ls_done, ls_rdata, m_req, m_we, m_addr, m_wdata, m_be, timeout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one shared memory port
module mem_port_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_arbiter_if.slave    bus
);
   localparam logic [7:0] TO = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, ERR} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        last_ls_q, last_ls_d;
   logic        m_req_q, m_req_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [3:0]  m_be_q, m_be_d;
   logic        if_done_q, if_done_d;
   logic        ls_done_q, ls_done_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        timeout_q, timeout_d;
   logic        if_elig, ls_elig;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_ls_d  = last_ls_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      m_be_d     = m_be_q;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      timeout_d  = timeout_q;
      // A requester whose done is high is dropping its request this cycle.
      if_elig    = bus.if_req && !if_done_q;
      ls_elig    = bus.ls_req && !ls_done_q;

      case (state_q)
         IDLE: begin
            if (if_elig && (!ls_elig || last_ls_q)) begin
               state_d   = BUSY_IF;
               cnt_d     = 8'd0;
               last_ls_d = 1'b0;
               m_req_d   = 1'b1;
               m_we_d    = 1'b0;
               m_addr_d  = bus.if_addr;
               m_wdata_d = 32'd0;
               m_be_d    = 4'b1111;
            end else if (ls_elig) begin
               state_d   = BUSY_LS;
               cnt_d     = 8'd0;
               last_ls_d = 1'b1;
               m_req_d   = 1'b1;
               m_we_d    = bus.ls_we;
               m_addr_d  = bus.ls_addr;
               m_wdata_d = bus.ls_wdata;
               m_be_d    = bus.ls_be;
            end
         end
         BUSY_IF, BUSY_LS: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (bus.m_ack) begin
               state_d = IDLE;
               m_req_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = bus.m_rdata;
               end else begin
                  ls_done_d  = 1'b1;
                  ls_rdata_d = m_we_q ? 32'd0 : bus.m_rdata;
               end
            end else if (cnt_q + 8'd1 == TO) begin
               state_d   = ERR;
               m_req_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         last_ls_q  <= 1'b1;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= 32'd0;
         m_wdata_q  <= 32'd0;
         m_be_q     <= 4'd0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_rdata_q <= 32'd0;
         ls_rdata_q <= 32'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_ls_q  <= last_ls_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         m_be_q     <= m_be_d;
         if_done_q  <= if_done_d;
         ls_done_q  <= ls_done_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.m_be     = m_be_q;
   assign bus.if_done  = if_done_q;
   assign bus.ls_done  = ls_done_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk;
   logic rst_n;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          len;
   } grant_t;

   typedef struct {
      logic        is_ls;
      logic [31:0] rdata;
   } done_t;

   grant_t gq[$];
   done_t  dq[$];

   int checks = 0;
   int errors = 0;

   logic        mem_en;
   logic        ack_force;
   int          wait_states;
   int          wcnt;
   logic [31:0] rdata_xor;

   // Memory model: acks after wait_states stalled cycles, data derived from address.
   assign bus.m_ack   = ack_force | (mem_en & bus.m_req & (wcnt == wait_states));
   assign bus.m_rdata = bus.m_addr ^ rdata_xor;

   always @(posedge clk) wcnt <= (bus.m_req && !bus.m_ack) ? wcnt + 1 : 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   task automatic exp_grant(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] be, input int len);
      grant_t g;
      g.addr = a; g.we = we; g.wdata = wd; g.be = be; g.len = len;
      gq.push_back(g);
   endtask

   task automatic exp_done(input logic is_ls, input logic [31:0] rd);
      done_t d;
      d.is_ls = is_ls; d.rdata = rd;
      dq.push_back(d);
   endtask

   task automatic run_until_done(input logic is_ls, input int max_cyc, output int n);
      n = 0;
      while (!(is_ls ? bus.ls_done : bus.if_done) && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      chk(is_ls ? "ls_done_seen" : "if_done_seen", 32'(is_ls ? bus.ls_done : bus.if_done), 32'd1);
      if (is_ls) bus.ls_req = 1'b0;
      else       bus.if_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic any_output();
      return |{bus.if_done, bus.if_rdata, bus.ls_done, bus.ls_rdata, bus.m_req, bus.m_we,
               bus.m_addr, bus.m_wdata, bus.m_be, bus.timeout};
   endfunction

   // Monitor: pops expected grants on m_req rise and expected completions on done pulses.
   initial begin
      grant_t cur;
      done_t  d;
      int     len;
      logic   prev;
      cur.addr = 0; cur.we = 0; cur.wdata = 0; cur.be = 0; cur.len = 0;
      len = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.if_done && bus.ls_done) chk("done_overlap", 32'd1, 32'd0);
            if (bus.m_req) begin
               if (!prev) begin
                  chk("grant_expected", 32'(gq.size() != 0), 32'd1);
                  if (gq.size() != 0) cur = gq.pop_front();
                  len = 0;
               end
               len++;
               chk("m_addr", bus.m_addr, cur.addr);
               chk("m_we", 32'(bus.m_we), 32'(cur.we));
               chk("m_wdata", bus.m_wdata, cur.wdata);
               chk("m_be", 32'(bus.m_be), 32'(cur.be));
            end else if (prev && cur.len != 0) begin
               chk("m_req_len", 32'(len), 32'(cur.len));
            end
            if (bus.if_done || bus.ls_done) begin
               chk("done_expected", 32'(dq.size() != 0), 32'd1);
               if (dq.size() != 0) begin
                  d = dq.pop_front();
                  chk("done_owner_ls", 32'(bus.ls_done), 32'(d.is_ls));
                  chk("done_rdata", d.is_ls ? bus.ls_rdata : bus.if_rdata, d.rdata);
               end
            end
         end
         prev = rst_n ? bus.m_req : 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1);
   end

   initial begin
      int n;
      int ndone;
      rst_n = 1'b0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_be = 0;
      mem_en = 1'b1; ack_force = 1'b0; wait_states = 0; rdata_xor = 0;
      idle(2);
      chk("reset_outputs", 32'(any_output()), 32'd0);
      rst_n = 1'b1;
      idle(3);
      chk("no_req_after_reset", 32'(bus.m_req), 32'd0);

      // Zero-wait fetch
      rdata_xor = 32'h0050_0193;
      exp_grant(32'h100, 1'b0, 32'd0, 4'hF, 1);
      exp_done(1'b0, 32'h0050_0093);
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      run_until_done(1'b0, 10, n);
      chk("fetch_latency", 32'(n), 32'd2);
      idle(3);
      chk("if_rdata_hold", bus.if_rdata, 32'h0050_0093);

      // Spurious ack in IDLE
      ack_force = 1'b1;
      idle(1);
      ack_force = 1'b0;
      idle(2);
      chk("spurious_m_req", 32'(bus.m_req), 32'd0);
      chk("spurious_if_rdata", bus.if_rdata, 32'h0050_0093);

      // Store with 3 wait states, inputs scrambled after grant
      rdata_xor = 32'h1234_5678; wait_states = 3;
      exp_grant(32'h2004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 4);
      exp_done(1'b1, 32'd0);
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h2004;
      bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_be = 4'b0011;
      idle(1);
      bus.ls_we = 1'b0; bus.ls_addr = 32'hFFFF_0000; bus.ls_wdata = 32'h0; bus.ls_be = 4'b1100;
      bus.if_addr = 32'h5555_5555;
      run_until_done(1'b1, 10, n);
      idle(2);

      // Fetch acked on the timeout cycle completes normally
      rdata_xor = 32'd0;
      exp_grant(32'h80, 1'b0, 32'd0, 4'hF, 4);
      exp_done(1'b0, 32'h80);
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      run_until_done(1'b0, 10, n);
      chk("ack_wins_timeout", 32'(bus.timeout), 32'd0);
      idle(2);

      // Contention from reset: IF, LS, IF, LS
      wait_states = 0;
      rst_n = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h3000;
      bus.ls_wdata = 32'h1111_2222; bus.ls_be = 4'b1100;
      for (int i = 0; i < 2; i++) begin
         exp_grant(32'h200, 1'b0, 32'd0, 4'hF, 1);
         exp_done(1'b0, 32'h200);
         exp_grant(32'h3000, 1'b0, 32'h1111_2222, 4'b1100, 1);
         exp_done(1'b1, 32'h3000);
      end
      idle(1);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40 && ndone < 4; i++) begin
         @(posedge clk); #1;
         if (bus.if_done || bus.ls_done) ndone++;
      end
      bus.if_req = 1'b0; bus.ls_req = 1'b0;
      chk("contention_dones", 32'(ndone), 32'd4);
      idle(3);
      chk("contention_grants_left", 32'(gq.size()), 32'd0);
      chk("contention_dones_left", 32'(dq.size()), 32'd0);

      // Reset mid-transfer, then a fresh fetch
      mem_en = 1'b0;
      exp_grant(32'h3000, 1'b0, 32'h1111_2222, 4'b1100, 0);
      bus.ls_req = 1'b1;
      idle(2);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", 32'(any_output()), 32'd0);
      bus.ls_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h300; mem_en = 1'b1;
      exp_grant(32'h300, 1'b0, 32'd0, 4'hF, 1);
      exp_done(1'b0, 32'h300);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_until_done(1'b0, 10, n);
      idle(3);
      chk("reset_grants_left", 32'(gq.size()), 32'd0);
      chk("reset_dones_left", 32'(dq.size()), 32'd0);

      // Timeout into absorbing ERR
      mem_en = 1'b0;
      exp_grant(32'h40, 1'b0, 32'd0, 4'hF, 4);
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      idle(8);
      chk("timeout_m_req", 32'(bus.m_req), 32'd0);
      chk("timeout_flag", 32'(bus.timeout), 32'd1);
      bus.if_req = 1'b0; bus.ls_req = 1'b1; mem_en = 1'b1;
      idle(10);
      chk("err_no_grant", 32'(bus.m_req), 32'd0);
      chk("err_flag_held", 32'(bus.timeout), 32'd1);
      chk("err_grants_left", 32'(gq.size()), 32'd0);
      chk("err_dones_left", 32'(dq.size()), 32'd0);
      bus.ls_req = 1'b0;
      rst_n = 1'b0;
      #1 chk("err_reset_flag", 32'(bus.timeout), 32'd0);
      idle(1);
      rst_n = 1'b1;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
